// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared defaults and von Neumann pair encodings for the TRNG core
package trng_pkg;

  localparam int TRNG_NUM_CH      = 4;
  localparam int TRNG_WIDTH       = 8;
  localparam int TRNG_FIFO_DEPTH  = 4;
  localparam int TRNG_REP_LIMIT   = 32;
  localparam int TRNG_SYNC_STAGES = 2;

  // {first, second} bit of a debias pair that produces output
  localparam logic [1:0] VN_PAIR_ONE  = 2'b10;
  localparam logic [1:0] VN_PAIR_ZERO = 2'b01;

endpackage

// File: rtl/trng_fifo.sv
// rtl/trng_fifo.sv - first-word fall-through FIFO; caller gates push against full and pop against empty
module trng_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;

  assign level    = level_q;
  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/trng_core_multi.sv
// rtl/trng_core_multi.sv - multi-channel TRNG: sync, XOR mix, health test, debias, word assembly, FIFO
module trng_core_multi
  import trng_pkg::*;
#(
  parameter int NUM_CH      = TRNG_NUM_CH,
  parameter int WIDTH       = TRNG_WIDTH,
  parameter int FIFO_DEPTH  = TRNG_FIFO_DEPTH,
  parameter int REP_LIMIT   = TRNG_REP_LIMIT,
  parameter int SYNC_STAGES = TRNG_SYNC_STAGES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [NUM_CH-1:0]                  raw_in,
  input  logic                               debias_en,
  input  logic                               clr_fail,
  input  logic                               rd_ready,
  output logic                               rd_valid,
  output logic [WIDTH-1:0]                   rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               health_fail
);

  localparam int CW   = 8;
  localparam int CNTW = $clog2(WIDTH);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic              mixed;

  logic [CW-1:0]     rep_cnt;
  logic [CW-1:0]     rep_inc;
  logic [CW-1:0]     rep_next;
  logic              prev_bit;
  logic              trigger;
  logic              fail_q;
  logic              debias_q;
  logic              dbe_change;

  logic              phase_q, phase_d;
  logic              first_q, first_d;
  logic              clear_path;
  logic              emit;
  logic              emit_bit;

  logic [WIDTH-1:0]  asm_q;
  logic [WIDTH-1:0]  asm_word;
  logic [CNTW-1:0]   asm_cnt;
  logic              word_done;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign mixed = ^sync_q[SYNC_STAGES-1];

  // a cleared counter (0) against any bit yields 1, so no separate first-bit flag is needed
  assign rep_inc    = (rep_cnt == CW'(REP_LIMIT)) ? rep_cnt : rep_cnt + 8'd1;
  assign rep_next   = (mixed == prev_bit) ? rep_inc : 8'd1;
  assign trigger    = en && (rep_next == CW'(REP_LIMIT));
  assign dbe_change = (debias_en != debias_q);

  always_comb begin
    emit       = 1'b0;
    emit_bit   = mixed;
    phase_d    = phase_q;
    first_d    = first_q;
    clear_path = clr_fail || dbe_change || trigger;
    if (!clear_path && en && !fail_q) begin
      if (debias_en) begin
        if (!phase_q) begin
          phase_d = 1'b1;
          first_d = mixed;
        end else begin
          phase_d = 1'b0;
          if ({first_q, mixed} == VN_PAIR_ONE || {first_q, mixed} == VN_PAIR_ZERO) begin
            emit     = 1'b1;
            emit_bit = first_q;
          end
        end
      end else begin
        emit = 1'b1;
      end
    end
  end

  assign asm_word  = {asm_q[WIDTH-2:0], emit_bit};
  assign word_done = emit && (asm_cnt == CNTW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt  <= '0;
      prev_bit <= 1'b0;
      fail_q   <= 1'b0;
      debias_q <= 1'b0;
      phase_q  <= 1'b0;
      first_q  <= 1'b0;
      asm_q    <= '0;
      asm_cnt  <= '0;
    end else begin
      debias_q <= debias_en;
      if (clr_fail) begin
        rep_cnt <= '0;
      end else if (en) begin
        rep_cnt  <= rep_next;
        prev_bit <= mixed;
      end
      if (clr_fail)     fail_q <= 1'b0;
      else if (trigger) fail_q <= 1'b1;
      if (clear_path) begin
        phase_q <= 1'b0;
        asm_q   <= '0;
        asm_cnt <= '0;
      end else begin
        phase_q <= phase_d;
        first_q <= first_d;
        if (emit) begin
          asm_q   <= asm_word;
          asm_cnt <= word_done ? '0 : asm_cnt + CNTW'(1);
        end
      end
    end
  end

  // a full FIFO still takes the word when the consumer frees a slot in the same cycle
  assign fifo_pop  = !fifo_empty && rd_ready;
  assign fifo_push = word_done && (!fifo_full || fifo_pop);

  trng_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (asm_word),
    .pop       (fifo_pop),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign rd_valid    = !fifo_empty;
  assign health_fail = fail_q;

endmodule

// File: tb/tb_trng_core_multi.sv
// tb/tb_trng_core_multi.sv - scoreboard bench for trng_core_multi with directed bit streams
module tb_trng_core_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] raw_in;
  logic       debias_en;
  logic       clr_fail;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] fifo_level;
  logic       health_fail;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  trng_core_multi dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .raw_in      (raw_in),
    .debias_en   (debias_en),
    .clr_fail    (clr_fail),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .fifo_level  (fifo_level),
    .health_fail (health_fail)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        chk("word", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // settle raw value through the synchroniser with en low, then consume it in one strobe
  task automatic send_raw(input logic [3:0] r);
    raw_in = r;
    en     = 1'b0;
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    if (^r != b) r[0] = ~r[0];
    send_raw(r);
  endtask

  task automatic send_seq(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic drain();
    @(posedge clk);
    #1 rd_ready = 1'b1;
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) @(posedge clk);
    #1 rd_ready = 1'b0;
    @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; raw_in = 4'h0; debias_en = 1'b0; clr_fail = 1'b0; rd_ready = 1'b0;

    // reset
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 raw_in = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_health", 32'(health_fail), 32'd0);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 raw_in = 4'hF;
    @(negedge clk);
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_level", 32'(fifo_level), 32'd0);

    // bypass: 1,0,1,0,1,1,0,0
    exp_q.push_back(8'hAC);
    send_seq(64'b10101100, 8);
    @(negedge clk);
    chk("bypass_valid", 32'(rd_valid), 32'd1);
    chk("bypass_data", 32'(rd_data), 32'hAC);
    chk("bypass_level", 32'(fifo_level), 32'd1);
    drain();

    // debias
    debias_en = 1'b1;
    repeat (2) @(posedge clk);
    exp_q.push_back(8'hB3);
    send_seq(64'b10_01_00_10_11_10_01_01_10_10, 20);
    @(negedge clk);
    chk("debias_data", 32'(rd_data), 32'hB3);
    chk("debias_level", 32'(fifo_level), 32'd1);
    drain();
    debias_en = 1'b0;

    // health: 32 identical bits, the 32nd triggers and is discarded
    pulse_reset();
    for (int i = 0; i < 31; i++) begin
      if (i % 8 == 7) exp_q.push_back(8'h00);
      send_raw(4'b0000);
    end
    @(negedge clk);
    chk("health_before", 32'(health_fail), 32'd0);
    chk("health_level31", 32'(fifo_level), 32'd3);
    send_raw(4'b0000);
    @(negedge clk);
    chk("health_set", 32'(health_fail), 32'd1);
    chk("health_level32", 32'(fifo_level), 32'd3);
    send_seq(64'b10101010, 8);
    @(negedge clk);
    chk("health_no_push", 32'(fifo_level), 32'd3);
    chk("health_sticky", 32'(health_fail), 32'd1);
    @(posedge clk);
    #1 clr_fail = 1'b1;
    @(posedge clk);
    #1 clr_fail = 1'b0;
    @(negedge clk);
    chk("health_cleared", 32'(health_fail), 32'd0);
    exp_q.push_back(8'hAA);
    send_seq(64'b10101010, 8);
    @(negedge clk);
    chk("health_restart_level", 32'(fifo_level), 32'd4);
    drain();

    // overflow: five words, fifth dropped
    for (int w = 0; w < 5; w++) begin
      if (w < 4) exp_q.push_back(8'hAA);
      send_seq(64'b10101010, 8);
    end
    @(negedge clk);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    drain();
    chk("ovf_level_after", 32'(fifo_level), 32'd0);

    // mid-operation reset
    send_seq(64'hAAAA, 16);
    send_seq(64'b1111, 4);
    @(negedge clk);
    chk("mid_level2", 32'(fifo_level), 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back(8'hAC);
    send_seq(64'b10101100, 8);
    @(negedge clk);
    chk("mid_partial_lost", 32'(rd_data), 32'hAC);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
